aes_inv_mixcolumns_seq: RTL and testbench

Iterative AES InvMixColumns unit for the decryption datapath: accepts a 128-bit state over a valid/ready handshake, applies the inverse MixColumns matrix {0e,0b,0d,09} one 32-bit column per clock, and presents the result on a held output handshake. It is the decryption-side counterpart of the combinational aes_mixcolumns. It trades 4 cycles of latency for a single column-wide GF(2^8) datapath, and sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_inv_mixcolumns_seq_if.sv | 32 +++
 rtl/aes_inv_mixcol_word.sv | 20 ++
 rtl/aes_inv_mixcolumns_seq.sv | 86 ++++++++
 tb/tb_aes_inv_mixcolumns_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers (modulus 0x11B).
// The same helpers are used by the forward MixColumns and the key schedule.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each inverse coefficient is assembled from the x2/x4/x8 chain of one operand.
    function automatic byte_t gmul9(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic byte_t gmulb(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic byte_t gmuld(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic byte_t gmule(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns_seq_if.sv
// Input/output handshake bundle for the iterative InvMixColumns unit.
interface aes_inv_mixcolumns_seq_if;

    logic           in_valid;
    logic           in_ready;
    aes_pkg::state_t in_state;
    logic           out_valid;
    logic           out_ready;
    aes_pkg::state_t out_state;
    logic           busy;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );

endinterface

// File: rtl/aes_inv_mixcol_word.sv
// Combinational InvMixColumns on one 32-bit column; byte [31:24] is row 0.
module aes_inv_mixcol_word
    import aes_pkg::*;
(
    input  word_t col_in,
    output word_t col_out
);

    byte_t s [NUM_ROWS];

    // Row gi uses {0e,0b,0d,09} rotated right by gi positions.
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        assign s[gi] = col_in[31-8*gi -: 8];
        assign col_out[31-8*gi -: 8] = gmule(s[gi])
                                     ^ gmulb(s[(gi+1)%NUM_ROWS])
                                     ^ gmuld(s[(gi+2)%NUM_ROWS])
                                     ^ gmul9(s[(gi+3)%NUM_ROWS]);
    end

endmodule

// File: rtl/aes_inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns: one column per clock through a shared column
// core, result held on a valid/ready output until accepted.
module aes_inv_mixcolumns_seq
    import aes_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    aes_inv_mixcolumns_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t       state_reg, state_next;
    logic [1:0] col_cnt_reg, col_cnt_next;
    state_t     work_reg, work_next;
    state_t     work_upd;
    word_t      cols [NUM_COLS];
    word_t      col_in;
    word_t      col_out;

    // Column gi of the working state, plus its write-back image when selected.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign cols[gi] = work_reg[127-32*gi -: 32];
        assign work_upd[127-32*gi -: 32] = (col_cnt_reg == 2'(gi)) ? col_out : cols[gi];
    end

    assign col_in = cols[col_cnt_reg];

    aes_inv_mixcol_word u_core (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            col_cnt_reg <= 2'd0;
            work_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            col_cnt_reg <= col_cnt_next;
            work_reg    <= work_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        col_cnt_next = col_cnt_reg;
        work_next    = work_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    work_next    = bus.in_state;
                    col_cnt_next = 2'd0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                work_next    = work_upd;
                col_cnt_next = col_cnt_reg + 2'd1;
                if (col_cnt_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs come only from registered state, never from in_valid/out_ready.
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_state = work_reg;

endmodule

// File: tb/tb_aes_inv_mixcolumns_seq.sv
// Bench for aes_inv_mixcolumns_seq: directed vectors, handshake timing and a
// random forward/inverse round trip against a generic GF(2^8) matrix model.
module tb_aes_inv_mixcolumns_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    aes_inv_mixcolumns_seq_if bus ();

    aes_inv_mixcolumns_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift-and-add multiply with bitwise reduction by 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product on every column; row r uses coefficients rotated right by r.
    function automatic logic [127:0] mix_ref(input logic [127:0] st, input logic [31:0] coeffs);
        logic [7:0]   k [4];
        logic [7:0]   acc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) k[i] = coeffs[31-8*i -: 8];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(k[(j - r + 4) % 4], st[127-8*(4*c+j) -: 8]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] st);
        return mix_ref(st, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_ref(input logic [127:0] st);
        return mix_ref(st, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents s, waits for acceptance, then for out_valid; returns at the first DONE sample.
    task automatic run_block(input logic [127:0] s, output logic [127:0] res, output int lat);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_state = rand_state();
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        res = bus.out_state;
    endtask

    initial begin
        logic [127:0] res, held, orig, fwd;
        logic [127:0] va, vb;
        logic [127:0] outs [2];
        int           acc_e [2];
        int           hs_e [2];
        int           na, no, lat;

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check_val("rst_in_ready",  128'(bus.in_ready),  128'd1);
        check_val("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_val("rst_busy",      128'(bus.busy),      128'd0);
        check_val("rst_out_state", bus.out_state,       128'd0);

        // Known FIPS-197 round vector
        va = 128'h046681e5e0cb199a48f8d37a2806264c;
        run_block(va, res, lat);
        $display("txn known: in=%h out=%h lat=%0d", va, res, lat);
        check_val("known_vec",   res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check_val("known_model", res, inv_ref(va));
        check_val("latency",     128'(lat), 128'd4);
        check_val("done_busy",   128'(bus.busy), 128'd1);
        tick();
        check_val("post_hs_ready", 128'(bus.in_ready),  128'd1);
        check_val("post_hs_valid", 128'(bus.out_valid), 128'd0);

        // Per-column known values
        va = 128'h8e4da1bc9fdc589dc6c6c6c64d7ebdf8;
        run_block(va, res, lat);
        $display("txn columns: in=%h out=%h lat=%0d", va, res, lat);
        check_val("col_vec", res, 128'hdb135345f20a225cc6c6c6c62d26314c);
        tick();

        // Backpressure with an ignored in_valid pulse while DONE
        bus.out_ready = 1'b0;
        va = rand_state();
        run_block(va, held, lat);
        $display("txn backpressure: in=%h out=%h lat=%0d", va, held, lat);
        check_val("bp_model", held, inv_ref(va));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.in_state = rand_state();
            end
            if (i == 4) bus.in_valid = 1'b0;
            tick();
            check_val("bp_valid", 128'(bus.out_valid), 128'd1);
            check_val("bp_state", bus.out_state, held);
            check_val("bp_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_release", 128'(bus.in_ready), 128'd1);
        repeat (6) tick();
        check_val("bp_no_phantom", 128'(bus.busy), 128'd0);

        // Back-to-back with in_valid held high
        va = rand_state();
        vb = rand_state();
        na = 0;
        no = 0;
        acc_e = '{0, 0};
        hs_e  = '{0, 0};
        outs  = '{128'd0, 128'd0};
        bus.in_valid = 1'b1;
        bus.in_state = va;
        for (int i = 0; i < 20; i++) begin
            logic acc_now;
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now && na < 2) begin
                acc_e[na] = cyc + 1;
                na++;
            end
            if (bus.out_valid && bus.out_ready && no < 2) begin
                outs[no] = bus.out_state;
                hs_e[no] = cyc + 1;
                no++;
            end
            tick();
            if (acc_now && na == 1) bus.in_state = vb;
            if (na == 2) bus.in_valid = 1'b0;
        end
        $display("txn b2b: acc=%0d,%0d hs=%0d,%0d", acc_e[0], acc_e[1], hs_e[0], hs_e[1]);
        check_val("b2b_first",   outs[0], inv_ref(va));
        check_val("b2b_second",  outs[1], inv_ref(vb));
        check_val("b2b_lat",     128'(hs_e[0] - acc_e[0]), 128'd5);
        check_val("b2b_spacing", 128'(acc_e[1] - hs_e[0]), 128'd1);

        // Reset during the second BUSY cycle
        bus.in_valid = 1'b1;
        bus.in_state = rand_state();
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_ready", 128'(bus.in_ready),  128'd1);
        check_val("midrst_valid", 128'(bus.out_valid), 128'd0);
        check_val("midrst_state", bus.out_state,       128'd0);
        check_val("midrst_busy",  128'(bus.busy),      128'd0);

        // Reset coinciding with an input handshake: no transfer
        bus.in_valid = 1'b1;
        bus.in_state = rand_state();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_val("rst_vs_accept", 128'(bus.busy), 128'd0);

        va = rand_state();
        run_block(va, res, lat);
        $display("txn after_reset: in=%h out=%h lat=%0d", va, res, lat);
        check_val("fresh_vec", res, inv_ref(va));
        check_val("fresh_lat", 128'(lat), 128'd4);
        tick();

        // Random round trip through the forward transform
        for (int it = 0; it < 1000; it++) begin
            orig = rand_state();
            fwd  = fwd_ref(orig);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            run_block(fwd, res, lat);
            $display("txn rand %0d: in=%h out=%h", it, fwd, res);
            check_val("roundtrip", res, orig);
            bus.out_ready = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
